audio_hold_ctrl: RTL and testbench

AUDIO_HOLD_CTRL -- requirements
Module: audio_hold_ctrl

---
 rtl/audio_hold_if.sv | 19 +
 rtl/audio_hold_ctrl.sv | 123 ++++++++++++
 tb/tb_audio_hold_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_hold_if.sv
// Handshake bundle between the hold requesters/frame clock and audio_hold_ctrl.
interface audio_hold_if;
    logic       frame_strobe;
    logic [1:0] req;
    logic       timeout_clr;
    logic [1:0] grant;
    logic       hold_output;
    logic       timeout;

    modport master (
        output frame_strobe, req, timeout_clr,
        input  grant, hold_output, timeout
    );

    modport slave (
        input  frame_strobe, req, timeout_clr,
        output grant, hold_output, timeout
    );
endinterface

// File: rtl/audio_hold_ctrl.sv
// Two-requester round-robin arbiter that freezes the audio sample buffer on frame boundaries.
// Optional forced release after HOLD_MAX_FRAMES: define AUDIO_HOLD_TIMEOUT_EN.
module audio_hold_ctrl #(
    parameter int HOLD_MAX_FRAMES = 255,
    parameter int CNT_W           = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    audio_hold_if.slave   if_hold
);

    typedef enum logic [1:0] {IDLE, ARM, HOLD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] L_MAX = CNT_W'(HOLD_MAX_FRAMES);

    state_t           r_state;
    logic             r_win;      // 0 = A, 1 = B
    logic             r_last;
    logic [1:0]       r_grant;
    logic             r_hold;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_elig;
    logic             w_pick;
    logic             w_win_req;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_win_onehot;

`ifdef AUDIO_HOLD_TIMEOUT_EN
    logic [1:0]       r_block;
    logic             r_timeout;
    logic             w_to_set;

    assign w_elig   = if_hold.req & ~r_block;
    assign w_to_set = (r_state == HOLD) && w_win_req && if_hold.frame_strobe &&
                      (w_cnt_nxt == L_MAX);

    // A timed-out requester stays blocked until its req is seen low; a new block wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_block   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_block <= (r_block & if_hold.req) | (w_to_set ? w_win_onehot : 2'b00);
            if (w_to_set)
                r_timeout <= 1'b1;
            else if (if_hold.timeout_clr)
                r_timeout <= 1'b0;
        end
    end

    assign if_hold.timeout = r_timeout;
`else
    logic w_unused_clr;

    assign w_elig          = if_hold.req;
    assign w_unused_clr    = if_hold.timeout_clr;
    assign if_hold.timeout = 1'b0;
`endif

    // Both eligible: whoever was not granted last; otherwise the lone eligible one.
    assign w_pick       = (w_elig == 2'b11) ? ~r_last : w_elig[1];
    assign w_win_req    = if_hold.req[r_win];
    assign w_win_onehot = r_win ? 2'b10 : 2'b01;
    assign w_cnt_nxt    = (r_cnt == L_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_grant <= '0;
            r_hold  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_elig) begin
                        r_win   <= w_pick;
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (!w_win_req) begin
                        r_state <= IDLE;
                    end else if (if_hold.frame_strobe) begin
                        r_grant <= w_win_onehot;
                        r_hold  <= 1'b1;
                        r_cnt   <= '0;
                        r_last  <= r_win;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!w_win_req) begin
                        r_grant <= '0;
                        r_state <= RELEASE;
                    end else if (if_hold.frame_strobe) begin
                        r_cnt <= w_cnt_nxt;
`ifdef AUDIO_HOLD_TIMEOUT_EN
                        if (w_cnt_nxt == L_MAX) begin
                            r_grant <= '0;
                            r_state <= RELEASE;
                        end
`endif
                    end
                end
                RELEASE: begin
                    // Buffer unfreezes only on a frame boundary.
                    if (if_hold.frame_strobe) begin
                        r_hold  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_hold.grant       = r_grant;
    assign if_hold.hold_output = r_hold;

endmodule

// File: tb/tb_audio_hold_ctrl.sv
// Directed bench for audio_hold_ctrl: per-cycle comparison against a request/owner model
// plus literal checks at the interesting points.
module tb_audio_hold_ctrl;

    localparam int MAXF = 4;
`ifdef AUDIO_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK;
    logic nRST;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    audio_hold_if ifc ();

    audio_hold_ctrl #(.HOLD_MAX_FRAMES(MAXF), .CNT_W(3)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .if_hold (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cand: requester waiting for a frame boundary; owner: requester holding the grant.
    typedef struct packed {
        int       cand;
        int       owner;
        bit       frozen;
        int       last;
        int       frames;
        bit       to;
        bit [1:0] blk;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t c, logic [1:0] rq, logic st, logic clr);
        mdl_t     n;
        bit [1:0] elig;
        bit       to_set;
        n      = c;
        to_set = 1'b0;
        elig   = rq & ~c.blk;
        n.blk  = c.blk & rq;
        if (c.cand < 0 && c.owner < 0 && !c.frozen) begin
            if (elig == 2'b11)  n.cand = 1 - c.last;
            else if (elig[0])   n.cand = 0;
            else if (elig[1])   n.cand = 1;
        end else if (c.cand >= 0) begin
            if (!rq[c.cand]) n.cand = -1;
            else if (st) begin
                n.owner  = c.cand;
                n.last   = c.cand;
                n.frozen = 1'b1;
                n.frames = 0;
                n.cand   = -1;
            end
        end else if (c.owner >= 0) begin
            if (!rq[c.owner]) n.owner = -1;
            else if (st) begin
                n.frames = (c.frames < MAXF) ? c.frames + 1 : MAXF;
                if (TO_EN && n.frames == MAXF) begin
                    to_set           = 1'b1;
                    n.blk[c.owner]   = 1'b1;
                    n.owner          = -1;
                end
            end
        end else if (st) begin
            n.frozen = 1'b0;
        end
        if (!TO_EN)      n.to = 1'b0;
        else if (to_set) n.to = 1'b1;
        else if (clr)    n.to = 1'b0;
        return n;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) m <= '{-1, -1, 1'b0, 1, 0, 1'b0, 2'b00};
        else       m <= step(m, ifc.req, ifc.frame_strobe, ifc.timeout_clr);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle advance goes through here, so the model is compared each cycle.
    task automatic tick();
        @(negedge CLK);
        if (chk_en) begin
            check("mdl_grant", ifc.grant, (m.owner < 0) ? 0 : (1 << m.owner));
            check("mdl_hold", ifc.hold_output, m.frozen);
            check("mdl_timeout", ifc.timeout, m.to);
            check("onehot", ($countones(ifc.grant) <= 1), 1);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe();
        ifc.frame_strobe = 1'b1;
        tick();
        ifc.frame_strobe = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b1;
        tick();
        nRST = 1'b0;
        ticks(2);
        nRST = 1'b1;
        chk_en = 1'b1;
        tick();
    endtask

    initial begin
        nRST             = 1'b1;
        ifc.req          = 2'b00;
        ifc.frame_strobe = 1'b0;
        ifc.timeout_clr  = 1'b0;

        do_reset();
        check("rst_grant", ifc.grant, 0);
        check("rst_hold", ifc.hold_output, 0);
        check("rst_timeout", ifc.timeout, 0);

        // Basic grant/release with one-cycle latency from each strobe
        ifc.req = 2'b01;
        ticks(9);
        check("arm_no_grant", ifc.grant, 0);
        strobe();
        check("hold_grant", ifc.grant, 1);
        check("hold_on", ifc.hold_output, 1);
        ticks(9);
        ifc.req = 2'b00;
        tick();
        check("drop_grant", ifc.grant, 0);
        check("still_held", ifc.hold_output, 1);
        ticks(8);
        check("held_until_strobe", ifc.hold_output, 1);
        strobe();
        check("release_hold", ifc.hold_output, 0);

        // Round-robin with both requesting
        do_reset();
        ifc.req = 2'b11;
        tick();
        strobe();
        check("rr_first_A", ifc.grant, 2'b01);
        ticks(3);
        ifc.req = 2'b10;
        tick();
        check("rr_A_drop", ifc.grant, 0);
        strobe();
        check("rr_rel", ifc.hold_output, 0);
        ifc.req = 2'b11;
        tick();
        strobe();
        check("rr_second_B", ifc.grant, 2'b10);

        // Abort in ARM, including drop coincident with strobe; pointer unchanged
        do_reset();
        ifc.req = 2'b01;
        tick();
        ifc.req = 2'b00;
        ticks(2);
        check("abort_grant", ifc.grant, 0);
        check("abort_hold", ifc.hold_output, 0);
        ifc.req = 2'b01;
        tick();
        ifc.req = 2'b00;
        strobe();
        check("abort_coinc_grant", ifc.grant, 0);
        check("abort_coinc_hold", ifc.hold_output, 0);
        ifc.req = 2'b11;
        tick();
        strobe();
        check("abort_then_A", ifc.grant, 2'b01);
        strobe();
        strobe();
        check("B_ignored", ifc.grant, 2'b01);

        // Asynchronous reset mid-HOLD
        #3 nRST = 1'b0;
        #1;
        check("async_grant", ifc.grant, 0);
        check("async_hold", ifc.hold_output, 0);
        ifc.req = 2'b10;
        ticks(2);
        #2 nRST = 1'b1;
        tick();
        strobe();
        check("post_rst_B", ifc.grant, 2'b10);
        check("post_rst_hold", ifc.hold_output, 1);

`ifdef AUDIO_HOLD_TIMEOUT_EN
        do_reset();
        ifc.req = 2'b01;
        tick();
        strobe();
        for (int i = 0; i < 3; i++) begin
            tick();
            strobe();
        end
        check("to_pre_grant", ifc.grant, 2'b01);
        check("to_pre_flag", ifc.timeout, 0);
        tick();
        ifc.timeout_clr = 1'b1;
        strobe();
        ifc.timeout_clr = 1'b0;
        check("to_grant_drop", ifc.grant, 0);
        check("to_set_wins", ifc.timeout, 1);
        check("to_hold_kept", ifc.hold_output, 1);
        ticks(2);
        strobe();
        check("to_released", ifc.hold_output, 0);
        ticks(4);
        strobe();
        ticks(2);
        check("to_no_regrant", ifc.grant, 0);
        check("to_no_rehold", ifc.hold_output, 0);
        ifc.req = 2'b00;
        tick();
        ifc.req = 2'b01;
        tick();
        strobe();
        check("to_regrant", ifc.grant, 2'b01);
        ifc.timeout_clr = 1'b1;
        tick();
        ifc.timeout_clr = 1'b0;
        check("to_cleared", ifc.timeout, 0);
`else
        do_reset();
        ifc.req = 2'b01;
        tick();
        strobe();
        for (int i = 0; i < 1000; i++) begin
            ifc.timeout_clr = (i % 7 == 0);
            tick();
            strobe();
        end
        ifc.timeout_clr = 1'b0;
        check("long_hold", ifc.hold_output, 1);
        check("long_grant", ifc.grant, 2'b01);
        check("long_timeout", ifc.timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
